// File: rtl/halloween_pkg.sv
// Shared opcode encoding, field widths and FSM state type for the Halloween command sequencer.
package halloween_pkg;

    localparam int unsigned OP_W    = 4;
    localparam int unsigned CLASS_W = 2;
    localparam int unsigned ARG_W   = 2;

    typedef struct packed {
        logic [CLASS_W-1:0] cls;
        logic [ARG_W-1:0]   arg;
    } opcode_t;

    localparam logic [OP_W-1:0]    OP_ON       = 4'b0000;
    localparam logic [OP_W-1:0]    OP_RESET    = 4'b0001;
    localparam logic [CLASS_W-1:0] CLS_SYS     = 2'b00;
    localparam logic [CLASS_W-1:0] CLS_COLOR   = 2'b01;
    localparam logic [CLASS_W-1:0] CLS_SOUND   = 2'b10;
    localparam logic [CLASS_W-1:0] CLS_EFFECT  = 2'b11;
    localparam logic [ARG_W-1:0]   ARG_INVALID = 2'b11;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_IDLE,
        ST_SOUND,
        ST_EFFECT
    } state_t;

endpackage

// File: rtl/halloween_cmd_fifo.sv
// Opcode FIFO with same-edge flush; flush wins over any push or pop in that cycle.
module halloween_cmd_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign head = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/halloween_cmd_sequencer.sv
// Round-robin opcode collector feeding a FIFO and a decoration control FSM
// (power, color, timed sound and timed effect).
module halloween_cmd_sequencer
    import halloween_pkg::*;
#(
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned FIFO_DEPTH    = 8,
    parameter int unsigned SOUND_CYCLES  = 16,
    parameter int unsigned EFFECT_CYCLES = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CH*4-1:0]           ch_op,
    input  logic [NUM_CH-1:0]             ch_valid,
    output logic [NUM_CH-1:0]             ch_ready,
    output logic                          powered,
    output logic [1:0]                    color,
    output logic                          color_set,
    output logic [1:0]                    sound_id,
    output logic                          sound_active,
    output logic [1:0]                    effect_id,
    output logic                          effect_active,
    output logic                          illegal_op,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned MAX_CYC = (SOUND_CYCLES > EFFECT_CYCLES) ? SOUND_CYCLES : EFFECT_CYCLES;
    localparam int unsigned TMR_W   = $clog2(MAX_CYC + 1);

    logic [CH_W-1:0]  rr_ptr;
    logic [CH_W-1:0]  grant_idx;
    logic             grant_any;
    logic [CH_W:0]    cand_sum;
    logic [CH_W-1:0]  cand;
    logic             full;
    logic             empty;
    logic             push;
    logic [OP_W-1:0]  push_op;
    logic [OP_W-1:0]  head_raw;
    opcode_t          head;
    logic             pop;
    logic             flush;

    state_t           state, state_n;
    logic [TMR_W-1:0] timer, timer_n;
    logic             powered_n, color_set_n, sound_active_n, effect_active_n, illegal_n;
    logic [1:0]       color_n, sound_id_n, effect_id_n;

    assign full  = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign empty = (fifo_count == '0);
    assign head  = opcode_t'(head_raw);

    // Round-robin search starting at rr_ptr; first valid channel wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand_sum  = '0;
        cand      = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand_sum = {1'b0, rr_ptr} + (CH_W+1)'(k);
            if (cand_sum >= (CH_W+1)'(NUM_CH)) cand_sum = cand_sum - (CH_W+1)'(NUM_CH);
            cand = cand_sum[CH_W-1:0];
            if (!grant_any && ch_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        ch_ready = '0;
        push_op  = '0;
        push     = grant_any && rst_n && !full;
        if (push) ch_ready[grant_idx] = 1'b1;
        for (int k = 0; k < NUM_CH; k++) begin
            if (CH_W'(k) == grant_idx) push_op = ch_op[k*OP_W +: OP_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (push) begin
            rr_ptr <= (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
        end
    end

    halloween_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (OP_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (push),
        .push_data (push_op),
        .pop       (pop),
        .head      (head_raw),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_OFF;
            timer         <= '0;
            powered       <= 1'b0;
            color         <= '0;
            color_set     <= 1'b0;
            sound_id      <= '0;
            sound_active  <= 1'b0;
            effect_id     <= '0;
            effect_active <= 1'b0;
            illegal_op    <= 1'b0;
        end else begin
            state         <= state_n;
            timer         <= timer_n;
            powered       <= powered_n;
            color         <= color_n;
            color_set     <= color_set_n;
            sound_id      <= sound_id_n;
            sound_active  <= sound_active_n;
            effect_id     <= effect_id_n;
            effect_active <= effect_active_n;
            illegal_op    <= illegal_n;
        end
    end

    // Timers load with N-1 so the active flag is high for exactly N cycles.
    always_comb begin
        state_n         = state;
        timer_n         = timer;
        powered_n       = powered;
        color_n         = color;
        color_set_n     = color_set;
        sound_id_n      = sound_id;
        sound_active_n  = sound_active;
        effect_id_n     = effect_id;
        effect_active_n = effect_active;
        illegal_n       = 1'b0;
        pop             = 1'b0;
        flush           = 1'b0;
        case (state)
            ST_OFF: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (head == OP_ON) begin
                        state_n   = ST_IDLE;
                        powered_n = 1'b1;
                    end
                end
            end
            ST_IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (head.arg == ARG_INVALID) begin
                        illegal_n = 1'b1;
                    end else begin
                        case (head.cls)
                            CLS_SYS: begin
                                if (head == OP_RESET) begin
                                    state_n         = ST_OFF;
                                    flush           = 1'b1;
                                    powered_n       = 1'b0;
                                    color_n         = '0;
                                    color_set_n     = 1'b0;
                                    sound_id_n      = '0;
                                    sound_active_n  = 1'b0;
                                    effect_id_n     = '0;
                                    effect_active_n = 1'b0;
                                end else if (head != OP_ON) begin
                                    illegal_n = 1'b1;
                                end
                            end
                            CLS_COLOR: begin
                                color_n     = head.arg;
                                color_set_n = 1'b1;
                            end
                            CLS_SOUND: begin
                                sound_id_n     = head.arg;
                                sound_active_n = 1'b1;
                                timer_n        = TMR_W'(SOUND_CYCLES - 1);
                                state_n        = ST_SOUND;
                            end
                            default: begin
                                effect_id_n     = head.arg;
                                effect_active_n = 1'b1;
                                timer_n         = TMR_W'(EFFECT_CYCLES - 1);
                                state_n         = ST_EFFECT;
                            end
                        endcase
                    end
                end
            end
            ST_SOUND: begin
                if (timer == '0) begin
                    sound_active_n = 1'b0;
                    state_n        = ST_IDLE;
                end else begin
                    timer_n = timer - TMR_W'(1);
                end
            end
            default: begin
                if (timer == '0) begin
                    effect_active_n = 1'b0;
                    state_n         = ST_IDLE;
                end else begin
                    timer_n = timer - TMR_W'(1);
                end
            end
        endcase
    end

endmodule

// File: tb/tb_halloween_cmd_sequencer.sv
// Directed scenarios plus randomized traffic, checked against a queue-based behavioural model.
module tb_halloween_cmd_sequencer;

    localparam int NUM_CH = 4;
    localparam int DEPTH  = 8;
    localparam int SND    = 16;
    localparam int EFF    = 32;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_CH*4-1:0]  ch_op;
    logic [NUM_CH-1:0]    ch_valid;
    logic [NUM_CH-1:0]    ch_ready;
    logic                 powered, color_set, sound_active, effect_active, illegal_op;
    logic [1:0]           color, sound_id, effect_id;
    logic [3:0]           fifo_count;

    halloween_cmd_sequencer #(
        .NUM_CH(NUM_CH), .FIFO_DEPTH(DEPTH), .SOUND_CYCLES(SND), .EFFECT_CYCLES(EFF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ch_op(ch_op), .ch_valid(ch_valid), .ch_ready(ch_ready),
        .powered(powered), .color(color), .color_set(color_set),
        .sound_id(sound_id), .sound_active(sound_active),
        .effect_id(effect_id), .effect_active(effect_active),
        .illegal_op(illegal_op), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int last_grant;
    int ill_seen, eff_seen, snd_seen;

    // Behavioural model: mode 0 off, 1 idle, 2 playing sound, 3 running effect.
    int       m_mode, m_left, m_rr;
    bit [3:0] m_q[$];
    bit       m_powered, m_color_set, m_snd_act, m_eff_act, m_illegal;
    bit [1:0] m_color, m_snd_id, m_eff_id;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_left = 0; m_rr = 0; m_q.delete();
        m_powered = 0; m_color_set = 0; m_snd_act = 0; m_eff_act = 0; m_illegal = 0;
        m_color = 0; m_snd_id = 0; m_eff_id = 0;
    endtask

    function automatic int model_grant(input logic rstv, input logic [NUM_CH-1:0] v);
        if (!rstv || m_q.size() >= DEPTH) return -1;
        for (int k = 0; k < NUM_CH; k++) begin
            int c = (m_rr + k) % NUM_CH;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_step(input logic rstv, input int g, input logic [3:0] op_in);
        bit       flushed;
        bit [3:0] op;
        if (!rstv) begin
            model_reset();
            return;
        end
        flushed   = 0;
        m_illegal = 0;
        if (m_mode >= 2) begin
            m_left--;
            if (m_left == 0) begin
                if (m_mode == 2) m_snd_act = 0; else m_eff_act = 0;
                m_mode = 1;
            end
        end else if (m_q.size() > 0) begin
            op = m_q.pop_front();
            if (m_mode == 0) begin
                if (op == 4'h0) begin m_mode = 1; m_powered = 1; end
            end else begin
                case (op)
                    4'h0: ;
                    4'h1: begin
                        m_mode = 0; m_q.delete(); flushed = 1;
                        m_powered = 0; m_color = 0; m_color_set = 0;
                        m_snd_id = 0; m_snd_act = 0; m_eff_id = 0; m_eff_act = 0;
                    end
                    4'h4, 4'h5, 4'h6: begin m_color = op[1:0]; m_color_set = 1; end
                    4'h8, 4'h9, 4'hA: begin m_snd_id = op[1:0]; m_snd_act = 1; m_left = SND; m_mode = 2; end
                    4'hC, 4'hD, 4'hE: begin m_eff_id = op[1:0]; m_eff_act = 1; m_left = EFF; m_mode = 3; end
                    default: m_illegal = 1;
                endcase
            end
        end
        if (g >= 0) begin
            if (!flushed) m_q.push_back(op_in);
            m_rr = (g + 1) % NUM_CH;
        end
    endtask

    task automatic run_cycle(input logic rstv, input logic [NUM_CH-1:0] v, input logic [4*NUM_CH-1:0] ops);
        int                g;
        logic [3:0]        op_in;
        logic [NUM_CH-1:0] exp_rdy;
        @(negedge clk);
        rst_n = rstv; ch_valid = v; ch_op = ops;
        g = model_grant(rstv, v);
        exp_rdy = '0;
        op_in   = '0;
        if (g >= 0) begin
            exp_rdy[g] = 1'b1;
            op_in = ops[g*4 +: 4];
        end
        #1;
        check_eq("ch_ready", 32'(ch_ready), 32'(exp_rdy));
        last_grant = g;
        @(posedge clk);
        model_step(rstv, g, op_in);
        #1;
        check_eq("powered",       32'(powered),       32'(m_powered));
        check_eq("color",         32'(color),         32'(m_color));
        check_eq("color_set",     32'(color_set),     32'(m_color_set));
        check_eq("sound_id",      32'(sound_id),      32'(m_snd_id));
        check_eq("sound_active",  32'(sound_active),  32'(m_snd_act));
        check_eq("effect_id",     32'(effect_id),     32'(m_eff_id));
        check_eq("effect_active", 32'(effect_active), 32'(m_eff_act));
        check_eq("illegal_op",    32'(illegal_op),    32'(m_illegal));
        check_eq("fifo_count",    32'(fifo_count),    32'(m_q.size()));
        if (illegal_op)    ill_seen++;
        if (effect_active) eff_seen++;
        if (sound_active)  snd_seen++;
    endtask

    task automatic send(input int ch, input logic [3:0] op);
        logic [NUM_CH-1:0]   v;
        logic [4*NUM_CH-1:0] ops;
        v = '0; ops = '0;
        v[ch] = 1'b1;
        ops[ch*4 +: 4] = op;
        run_cycle(1'b1, v, ops);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle(1'b1, '0, '0);
    endtask

    function automatic logic [3:0] rand_op();
        int r = $urandom_range(0, 99);
        logic [3:0] bad [5] = '{4'h3, 4'h7, 4'hB, 4'hF, 4'h2};
        if (r < 15) return 4'h0;
        if (r < 18) return 4'h1;
        if (r < 30) return bad[$urandom_range(0, 4)];
        return {2'($urandom_range(1, 3)), 2'($urandom_range(0, 2))};
    endfunction

    initial begin
        logic [NUM_CH-1:0]   v;
        logic [4*NUM_CH-1:0] ops;
        int                  dens;
        rst_n = 1'b0; ch_valid = '0; ch_op = '0;
        model_reset();

        run_cycle(1'b0, '0, '0);
        run_cycle(1'b0, 4'hF, '0);
        check_eq("rst_count", 32'(fifo_count), 32'd0);

        // Power on then choose purple on channel 2.
        send(2, 4'h0);
        send(2, 4'h5);
        check_eq("on_powered", 32'(powered), 32'd1);
        check_eq("on_no_color_yet", 32'(color_set), 32'd0);
        idle(1);
        check_eq("color_purple", 32'(color), 32'd1);
        check_eq("color_set", 32'(color_set), 32'd1);

        // Boo on channel 1 for exactly SND cycles; queued orange waits for it.
        snd_seen = 0;
        send(1, 4'hA);
        send(1, 4'h6);
        check_eq("boo_start", 32'(sound_active), 32'd1);
        check_eq("boo_id", 32'(sound_id), 32'd2);
        snd_seen = 1;
        idle(40);
        check_eq("boo_length", 32'(snd_seen), 32'(SND));
        check_eq("orange_after", 32'(color), 32'd2);
        check_eq("boo_id_held", 32'(sound_id), 32'd2);

        // Fog from channel 3, then all channels request while the FIFO fills.
        send(3, 4'hE);
        for (int i = 0; i < DEPTH; i++) begin
            run_cycle(1'b1, 4'hF, {NUM_CH{4'h4}});
            check_eq("rr_order", 32'(last_grant), 32'(i % NUM_CH));
        end
        check_eq("full_count", 32'(fifo_count), 32'(DEPTH));
        check_eq("fog_running", 32'(effect_active), 32'd1);
        run_cycle(1'b1, 4'hF, {NUM_CH{4'h4}});
        check_eq("full_no_ready", 32'(ch_ready), 32'd0);

        // Reset pulse mid-effect with a full FIFO.
        run_cycle(1'b0, 4'hF, {NUM_CH{4'h4}});
        check_eq("rst_mid_ready", 32'(ch_ready), 32'd0);
        check_eq("rst_mid_effect", 32'(effect_active), 32'd0);
        check_eq("rst_mid_count", 32'(fifo_count), 32'd0);

        // While off, an effect opcode is silently dropped before ON.
        ill_seen = 0; eff_seen = 0;
        send(0, 4'hC);
        send(0, 4'h0);
        idle(2);
        check_eq("off_no_effect", 32'(eff_seen), 32'd0);
        check_eq("off_no_illegal", 32'(ill_seen), 32'd0);
        check_eq("off_powered", 32'(powered), 32'd1);

        // Illegal, then RESET flushes a trailing color.
        send(0, 4'h6);
        idle(1);
        ill_seen = 0;
        send(0, 4'h3);
        send(0, 4'h1);
        send(0, 4'h4);
        idle(3);
        check_eq("illegal_once", 32'(ill_seen), 32'd1);
        check_eq("reset_powered", 32'(powered), 32'd0);
        check_eq("reset_count", 32'(fifo_count), 32'd0);
        check_eq("reset_color_set", 32'(color_set), 32'd0);

        // Randomized traffic with varying request density and rare resets.
        for (int i = 0; i < 3000; i++) begin
            case ((i / 200) % 3)
                0:       dens = 90;
                1:       dens = 30;
                default: dens = 5;
            endcase
            v = '0; ops = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                v[c] = ($urandom_range(0, 99) < dens);
                ops[c*4 +: 4] = rand_op();
            end
            run_cycle(($urandom_range(0, 499) != 0), v, ops);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
